// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a decoupling fetch queue.
// Generates the fetch PC, arbitrates redirects by priority, flushes stale work,
// owns the instruction RAM (with a monitor port) and presents {pc,inst} to ID
// over a valid/ready handshake. ID only ever sees queue registers, never the
// RAM output directly.
module if_fetch_queue #(
  parameter int          IRAM_AW  = 12,
  parameter int          FQ_DEPTH = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cpu_start,
  input  logic [29:0]                        start_adr,
  input  logic                               trap_ex,
  input  logic [29:0]                        csr_mtvec_ex,
  input  logic                               cmd_mret_ex,
  input  logic [29:0]                        csr_mepc_ex,
  input  logic                               cmd_sret_ex,
  input  logic [29:0]                        csr_sepc_ex,
  input  logic                               jmp_cond_ex,
  input  logic [29:0]                        jmp_adr_ex,
  output logic                               id_valid,
  input  logic                               id_ready,
  output logic [29:0]                        id_pc,
  output logic [31:0]                        id_inst,
  output logic                               post_jump_cmd,
  output logic [$clog2(FQ_DEPTH+1)-1:0]      fq_count,
  output logic [31:0]                        pc_data,
  input  logic                               i_read_sel,
  input  logic [IRAM_AW-1:0]                 i_ram_radr,
  output logic [31:0]                        i_ram_rdata,
  input  logic [IRAM_AW-1:0]                 i_ram_wadr,
  input  logic [31:0]                        i_ram_wdata,
  input  logic                               i_ram_wen
);

  localparam int              PTR_W     = $clog2(FQ_DEPTH);
  localparam int              CNT_W     = $clog2(FQ_DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_OCC = (CNT_W + 1)'(FQ_DEPTH);

  // Fetch-side state
  logic [29:0]        pc_if;
  logic               rd_pend;   // a RAM read issued last cycle returns data now
  logic [29:0]        rd_pc;     // PC belonging to that read
  logic               trap_q;    // a trap redirect was taken last cycle

  // Instruction RAM
  logic [31:0]        iram [0:(2**IRAM_AW)-1];
  logic [31:0]        ram_q;
  logic [IRAM_AW-1:0] ram_radr;

  // Fetch queue storage
  logic [29:0]        fq_pc   [FQ_DEPTH];
  logic [31:0]        fq_inst [FQ_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;

  // Per-cycle control
  logic               ex_req;
  logic               redirect;
  logic [29:0]        redir_pc;
  logic [CNT_W:0]     occ;
  logic               issue;
  logic               push;
  logic               pop;

  assign ex_req = cmd_mret_ex | cmd_sret_ex | jmp_cond_ex;

  // Redirect arbitration: start > trap > mret > sret > jump; EX redirects
  // right after a taken trap come from the wrong path and are dropped.
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    redirect = 1'b0;
    redir_pc = pc_if;
    if (cpu_start) begin
      redirect = 1'b1;
      redir_pc = start_adr;
    end else if (trap_ex) begin
      redirect = 1'b1;
      redir_pc = csr_mtvec_ex;
    end else if (!trap_q) begin
      if (cmd_mret_ex) begin
        redirect = 1'b1;
        redir_pc = csr_mepc_ex;
      end else if (cmd_sret_ex) begin
        redirect = 1'b1;
        redir_pc = csr_sepc_ex;
      end else if (jmp_cond_ex) begin
        redirect = 1'b1;
        redir_pc = jmp_adr_ex;
      end
    end
  end

  // Credit check counts both queued entries and the read still in flight,
  // so a returning read always finds a free slot.
  assign occ      = {1'b0, fq_count} + {{CNT_W{1'b0}}, rd_pend};
  assign issue    = ~redirect & ~i_read_sel & (occ < DEPTH_OCC);
  assign push     = rd_pend & ~redirect;
  assign pop      = id_valid & id_ready & ~redirect;
  assign ram_radr = i_read_sel ? i_ram_radr : pc_if[IRAM_AW-1:0];

  // Instruction RAM: synchronous write, registered read (old data on collision).
  // NOTE: the RAM array has no reset; only the small queue registers do.
  always_ff @(posedge clk) begin
    if (i_ram_wen) iram[i_ram_wadr] <= i_ram_wdata;
    ram_q <= iram[ram_radr];
  end

  assign i_ram_rdata = ram_q;

  // PC generation, in-flight read tracking and redirect history.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_if         <= RESET_PC;
      rd_pend       <= 1'b0;
      rd_pc         <= '0;
      trap_q        <= 1'b0;
      post_jump_cmd <= 1'b0;
    end else begin
      trap_q        <= trap_ex & ~cpu_start;
      post_jump_cmd <= ex_req;
      rd_pend       <= issue;
      if (issue) rd_pc <= pc_if;
      if (redirect)   pc_if <= redir_pc;
      else if (issue) pc_if <= pc_if + 30'd1;
    end
  end

  // Fetch queue: circular buffer, fully cleared on any redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      fq_count <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_pc[i]   <= '0;
        fq_inst[i] <= '0;
      end
    end else if (redirect) begin
      head     <= '0;
      tail     <= '0;
      fq_count <= '0;
    end else begin
      if (push) begin
        fq_pc[tail]   <= rd_pc;
        fq_inst[tail] <= ram_q;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   fq_count <= fq_count + CNT_W'(1);
        2'b01:   fq_count <= fq_count - CNT_W'(1);
        default: fq_count <= fq_count;
      endcase
    end
  end

  assign id_valid = (fq_count != '0);
  assign id_pc    = fq_pc[head];
  assign id_inst  = fq_inst[head];
  assign pc_data  = {pc_if, 2'b00};

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: a directed cycle table for start-up, stall,
// jump/trap/mret/start redirects, a monitor-port sequence, an asynchronous
// reset check, then randomized traffic compared against a queue-based model.
module tb_if_fetch_queue;

  localparam int FQ_DEPTH = 4;
  localparam int IRAM_AW  = 12;

  logic        clk;
  logic        rst_n;
  logic        cpu_start;
  logic [29:0] start_adr;
  logic        trap_ex;
  logic [29:0] csr_mtvec_ex;
  logic        cmd_mret_ex;
  logic [29:0] csr_mepc_ex;
  logic        cmd_sret_ex;
  logic [29:0] csr_sepc_ex;
  logic        jmp_cond_ex;
  logic [29:0] jmp_adr_ex;
  logic        id_valid;
  logic        id_ready;
  logic [29:0] id_pc;
  logic [31:0] id_inst;
  logic        post_jump_cmd;
  logic [2:0]  fq_count;
  logic [31:0] pc_data;
  logic        i_read_sel;
  logic [11:0] i_ram_radr;
  logic [31:0] i_ram_rdata;
  logic [11:0] i_ram_wadr;
  logic [31:0] i_ram_wdata;
  logic        i_ram_wen;

  if_fetch_queue #(.IRAM_AW(IRAM_AW), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(30'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_start(cpu_start), .start_adr(start_adr),
    .trap_ex(trap_ex), .csr_mtvec_ex(csr_mtvec_ex),
    .cmd_mret_ex(cmd_mret_ex), .csr_mepc_ex(csr_mepc_ex),
    .cmd_sret_ex(cmd_sret_ex), .csr_sepc_ex(csr_sepc_ex),
    .jmp_cond_ex(jmp_cond_ex), .jmp_adr_ex(jmp_adr_ex),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .post_jump_cmd(post_jump_cmd), .fq_count(fq_count), .pc_data(pc_data),
    .i_read_sel(i_read_sel), .i_ram_radr(i_ram_radr), .i_ram_rdata(i_ram_rdata),
    .i_ram_wadr(i_ram_wadr), .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [11:0] a);
    return ({20'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  logic [31:0] mem_m [4096];

  // ---------------- directed table ----------------
  typedef struct {
    logic        rdy, st, tr, mr, jp;
    logic [29:0] tgt;
    logic        e_valid;
    logic [29:0] e_pc;
    int          e_cnt;
    logic [29:0] e_pcif;
    logic        e_pj;
  } vec_t;

  vec_t vec [28];

  task automatic set_row(input int k, input logic ev, input logic [29:0] epc, input int ecnt,
                         input logic [29:0] epcif, input logic epj,
                         input logic rdy, input logic st, input logic tr, input logic mr,
                         input logic jp, input logic [29:0] tgt);
    vec[k] = '{rdy: rdy, st: st, tr: tr, mr: mr, jp: jp, tgt: tgt,
               e_valid: ev, e_pc: epc, e_cnt: ecnt, e_pcif: epcif, e_pj: epj};
  endtask

  task automatic drive_idle(input logic rdy);
    cpu_start = 0; trap_ex = 0; cmd_mret_ex = 0; cmd_sret_ex = 0; jmp_cond_ex = 0;
    id_ready = rdy;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [29:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_pend;
  logic        m_pend_v;
  logic [29:0] m_pc;
  logic        m_trap_last;
  logic        m_pj;
  logic [31:0] m_rdata;
  logic        m_rdata_v;

  task automatic model_reset();
    mq.delete();
    m_pend_v    = 0;
    m_pc        = 30'h0;
    m_trap_last = 0;
    m_pj        = 0;
    m_rdata_v   = 0;
  endtask

  // Advance the model over one clock edge using the inputs currently driven.
  task automatic model_step();
    logic        redir;
    logic [29:0] tgt;
    logic [31:0] rd;
    bit          issue;
    redir = 1;
    tgt   = '0;
    if (cpu_start)                     tgt = start_adr;
    else if (trap_ex)                  tgt = csr_mtvec_ex;
    else if (!m_trap_last && cmd_mret_ex) tgt = csr_mepc_ex;
    else if (!m_trap_last && cmd_sret_ex) tgt = csr_sepc_ex;
    else if (!m_trap_last && jmp_cond_ex) tgt = jmp_adr_ex;
    else redir = 0;
    rd = mem_m[i_read_sel ? i_ram_radr : m_pc[11:0]];
    if (redir) begin
      mq.delete();
      m_pend_v = 0;
      m_pc     = tgt;
    end else begin
      issue = !i_read_sel && ((mq.size() + int'(m_pend_v)) < FQ_DEPTH);
      if (mq.size() > 0 && id_ready) void'(mq.pop_front());
      if (m_pend_v) mq.push_back(m_pend);
      m_pend_v = issue;
      if (issue) begin
        m_pend = '{pc: m_pc, inst: mem_m[m_pc[11:0]]};
        m_pc   = m_pc + 30'd1;
      end
    end
    m_trap_last = trap_ex && !cpu_start;
    m_pj        = cmd_mret_ex | cmd_sret_ex | jmp_cond_ex;
    if (i_ram_wen) mem_m[i_ram_wadr] = i_ram_wdata;
    m_rdata   = rd;
    m_rdata_v = 1;
  endtask

  task automatic model_compare();
    check("rnd_id_valid", id_valid, mq.size() != 0);
    check("rnd_fq_count", fq_count, mq.size());
    check("rnd_pc_data", pc_data, {m_pc, 2'b00});
    check("rnd_post_jump", post_jump_cmd, m_pj);
    if (m_rdata_v) check("rnd_rdata", i_ram_rdata, m_rdata);
    if (mq.size() != 0) begin
      check("rnd_id_pc", id_pc, mq[0].pc);
      check("rnd_id_inst", id_inst, mq[0].inst);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [29:0] t;
    rst_n = 0;
    drive_idle(1'b0);
    start_adr = '0; csr_mtvec_ex = '0; csr_mepc_ex = '0; csr_sepc_ex = '0; jmp_adr_ex = '0;
    i_read_sel = 0; i_ram_radr = '0; i_ram_wadr = '0; i_ram_wdata = '0; i_ram_wen = 0;

    // Table: expected outputs at negedge k, then inputs for the next edge.
    //          k  valid  pc       cnt pc_if    pj  rdy st tr mr jp tgt
    set_row( 0, 0, 30'h0,   0, 30'h0,   0,  1, 0, 0, 0, 0, 30'h0);
    set_row( 1, 0, 30'h0,   0, 30'h1,   0,  1, 0, 0, 0, 0, 30'h0);
    set_row( 2, 1, 30'h0,   1, 30'h2,   0,  1, 0, 0, 0, 0, 30'h0);
    set_row( 3, 1, 30'h1,   1, 30'h3,   0,  0, 0, 0, 0, 0, 30'h0);
    set_row( 4, 1, 30'h1,   2, 30'h4,   0,  0, 0, 0, 0, 0, 30'h0);
    set_row( 5, 1, 30'h1,   3, 30'h5,   0,  0, 0, 0, 0, 0, 30'h0);
    for (int k = 6; k <= 12; k++)
      set_row(k, 1, 30'h1, 4, 30'h5, 0,  0, 0, 0, 0, 0, 30'h0);
    set_row(13, 1, 30'h1,   4, 30'h5,   0,  1, 0, 0, 0, 1, 30'h10);  // jump -> 0x40, pop ignored
    set_row(14, 0, 30'h0,   0, 30'h40,  1,  1, 0, 0, 0, 0, 30'h0);
    set_row(15, 0, 30'h0,   0, 30'h41,  0,  1, 0, 0, 0, 0, 30'h0);
    set_row(16, 1, 30'h40,  1, 30'h42,  0,  1, 0, 0, 0, 0, 30'h0);
    set_row(17, 1, 30'h41,  1, 30'h43,  0,  1, 0, 1, 0, 0, 30'h10);  // trap -> 0x10
    set_row(18, 0, 30'h0,   0, 30'h10,  0,  1, 0, 0, 0, 1, 30'h50);  // wrong-path jump
    set_row(19, 0, 30'h0,   0, 30'h11,  1,  1, 0, 0, 0, 0, 30'h0);
    set_row(20, 1, 30'h10,  1, 30'h12,  0,  1, 0, 0, 0, 0, 30'h0);
    set_row(21, 1, 30'h11,  1, 30'h13,  0,  1, 0, 1, 1, 1, 30'h20);  // trap+mret+jump
    set_row(22, 0, 30'h0,   0, 30'h20,  1,  1, 0, 0, 0, 0, 30'h0);
    set_row(23, 0, 30'h0,   0, 30'h21,  0,  1, 0, 0, 0, 0, 30'h0);
    set_row(24, 1, 30'h20,  1, 30'h22,  0,  1, 1, 0, 0, 0, 30'h100); // start while busy
    set_row(25, 0, 30'h0,   0, 30'h100, 0,  1, 0, 0, 0, 0, 30'h0);
    set_row(26, 0, 30'h0,   0, 30'h101, 0,  1, 0, 0, 0, 0, 30'h0);
    set_row(27, 1, 30'h100, 1, 30'h102, 0,  1, 0, 0, 0, 0, 30'h0);

    // Preload the whole RAM through the monitor write port while in reset.
    for (int a = 0; a < 4096; a++) begin
      @(negedge clk);
      i_ram_wen   = 1;
      i_ram_wadr  = 12'(a);
      i_ram_wdata = inst_of(12'(a));
      mem_m[a]    = inst_of(12'(a));
    end
    @(negedge clk);
    i_ram_wen = 0;
    rst_n     = 1;

    for (int k = 0; k < 28; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("tbl%0d_valid", k), id_valid, vec[k].e_valid);
      check($sformatf("tbl%0d_count", k), fq_count, vec[k].e_cnt);
      check($sformatf("tbl%0d_pc_data", k), pc_data, {vec[k].e_pcif, 2'b00});
      check($sformatf("tbl%0d_post_jump", k), post_jump_cmd, vec[k].e_pj);
      if (vec[k].e_valid) begin
        check($sformatf("tbl%0d_id_pc", k), id_pc, vec[k].e_pc);
        check($sformatf("tbl%0d_id_inst", k), id_inst, inst_of(vec[k].e_pc[11:0]));
      end
      id_ready     = vec[k].rdy;
      cpu_start    = vec[k].st;
      trap_ex      = vec[k].tr;
      cmd_mret_ex  = vec[k].mr;
      cmd_sret_ex  = 0;
      jmp_cond_ex  = vec[k].jp;
      start_adr    = vec[k].tgt;
      csr_mtvec_ex = vec[k].tgt;
      csr_mepc_ex  = vec[k].tgt + 30'h10;
      csr_sepc_ex  = vec[k].tgt + 30'h20;
      jmp_adr_ex   = vec[k].tgt + 30'h30;
    end

    // Monitor port: read-during-write returns old data, fetch frozen.
    @(negedge clk);
    drive_idle(1'b1);
    check("mon_pc_before", pc_data, {30'h103, 2'b00});
    i_read_sel  = 1;
    i_ram_radr  = 12'd5;
    i_ram_wen   = 1;
    i_ram_wadr  = 12'd5;
    i_ram_wdata = 32'hDEAD_BEEF;
    mem_m[5]    = 32'hDEAD_BEEF;
    @(negedge clk);
    i_ram_wen = 0;
    check("mon_rdw_old", i_ram_rdata, inst_of(12'd5));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mon_rdata_new", i_ram_rdata, 32'hDEAD_BEEF);
      check("mon_pc_frozen", pc_data, {30'h103, 2'b00});
    end
    i_read_sel = 0;

    // Asynchronous reset in the middle of a clock phase.
    @(negedge clk);
    #3 rst_n = 0;
    #1;
    check("arst_valid", id_valid, 1'b0);
    check("arst_count", fq_count, 3'd0);
    check("arst_pc", pc_data, 32'h0);
    check("arst_post_jump", post_jump_cmd, 1'b0);
    check("arst_id_pc", id_pc, 30'h0);
    check("arst_id_inst", id_inst, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      model_compare();
      id_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) i_read_sel = ~i_read_sel;
      r = $urandom; i_ram_radr = r[11:0];
      i_ram_wen = ($urandom_range(0, 19) == 0);
      r = $urandom; i_ram_wadr = r[11:0];
      i_ram_wdata = $urandom;
      trap_ex     = ($urandom_range(0, 39) == 0);
      cpu_start   = ($urandom_range(0, 99) == 0) && !trap_ex && !m_trap_last;
      cmd_mret_ex = ($urandom_range(0, 24) == 0);
      cmd_sret_ex = ($urandom_range(0, 24) == 0);
      jmp_cond_ex = ($urandom_range(0, 24) == 0);
      r = $urandom; t = r[29:0];
      if ($urandom_range(0, 7) == 0) t = 30'h3FFF_FFFE;
      start_adr    = t;
      csr_mtvec_ex = t ^ 30'h0000_0111;
      csr_mepc_ex  = t ^ 30'h0000_0222;
      csr_sepc_ex  = t ^ 30'h0000_0333;
      jmp_adr_ex   = t ^ 30'h0000_0444;
      model_step();
    end
    @(negedge clk);
    model_compare();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
